chol_recip_square: RTL and testbench

//   Inverse of chol_inv_sqrt: given Q16.16 unsigned y, returns x = 1/(y*y) in Q16.16.

---
 rtl/chol_pkg.sv | 21 ++
 rtl/chol_mult_q16.sv | 62 ++++++
 rtl/chol_recip_square.sv | 204 ++++++++++++++++++++
 tb/tb_chol_recip_square.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/chol_pkg.sv
// ---------------------------------------------------------------------------
// chol_pkg
//   Shared constants for the Cholesky fixed-point datapath.
//   - Q16.16 unsigned constants (one, two, saturated maximum).
//   - One-hot state encodings for the chol_recip_square sequencer.
// ---------------------------------------------------------------------------
package chol_pkg;

   localparam logic [31:0] Q16_ONE = 32'h0001_0000;
   localparam logic [31:0] Q16_TWO = 32'h0002_0000;
   localparam logic [31:0] Q16_MAX = 32'hFFFF_FFFF;

   // One-hot sequencer states
   localparam logic [5:0] S_IDLE   = 6'b00_0001;
   localparam logic [5:0] S_SQUARE = 6'b00_0010;
   localparam logic [5:0] S_SEED   = 6'b00_0100;
   localparam logic [5:0] S_MUL_T  = 6'b00_1000;
   localparam logic [5:0] S_SUB    = 6'b01_0000;
   localparam logic [5:0] S_MUL_R  = 6'b10_0000;

endpackage

// File: rtl/chol_mult_q16.sv
// ---------------------------------------------------------------------------
// chol_mult_q16
//   Pipelined unsigned Q16.16 x Q16.16 multiplier with clock enable.
//   The 64-bit product is truncated to P[47:16]; any set bit in P[63:48]
//   saturates the result to all-ones and raises sat.
//   Operands are sampled on an enabled clock edge and the result appears
//   on p/sat after LATENCY enabled edges.
// Ports
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset (clears the pipe)
//   ce     in   clock enable; low freezes every pipeline stage
//   a, b   in   Q16.16 unsigned operands
//   p      out  Q16.16 unsigned product (saturated)
//   sat    out  product overflowed
// ---------------------------------------------------------------------------
module chol_mult_q16
   import chol_pkg::*;
#(
   parameter int LATENCY = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ce,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] p,
   output logic        sat
);

   logic [63:0] prod;
   logic [32:0] pipe_d [LATENCY];
   logic [32:0] pipe_q [LATENCY];

   // First stage takes the saturated product; later stages just shift
   always_comb begin
      prod = {32'd0, a} * {32'd0, b};
      if (prod[63:48] != 16'd0) begin
         pipe_d[0] = {1'b1, Q16_MAX};
      end else begin
         pipe_d[0] = {1'b0, prod[47:16]};
      end
      for (int i = 1; i < LATENCY; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LATENCY; i++) begin
            pipe_q[i] <= 33'd0;
         end
      end else if (ce) begin
         for (int i = 0; i < LATENCY; i++) begin
            pipe_q[i] <= pipe_d[i];
         end
      end
   end

   assign p   = pipe_q[LATENCY-1][31:0];
   assign sat = pipe_q[LATENCY-1][32];

endmodule

// File: rtl/chol_recip_square.sv
// ---------------------------------------------------------------------------
// chol_recip_square
//   Computes x = 1/(y*y) in Q16.16: squares y, seeds a reciprocal of the
//   square from its MSB position, then refines with ITER Newton-Raphson
//   steps r <- r*(2 - s*r). A single time-shared multiplier does all
//   products. Latency is fixed: MUL_LATENCY+1+ITER*(2*MUL_LATENCY+2)
//   enabled cycles from accept to out_valid.
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   clken        global enable; low freezes sequencer and multiplier
//   data_valid   request strobe, only sampled while ready
//   data         y, Q16.16 unsigned
//   ready        sequencer idle, request can be accepted
//   out          x = 1/y^2, Q16.16 unsigned
//   out_valid    result valid, held until the next accepted request
//   out_sat      result saturated, qualified by out_valid
// ---------------------------------------------------------------------------
module chol_recip_square
   import chol_pkg::*;
#(
   parameter int ITER        = 4,
   parameter int MUL_LATENCY = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clken,
   input  logic        data_valid,
   input  logic [31:0] data,
   output logic        ready,
   output logic [31:0] out,
   output logic        out_valid,
   output logic        out_sat
);

   localparam logic [3:0] CNT_LAST  = 4'(MUL_LATENCY - 1);
   localparam logic [3:0] CNT_ISSUE = 4'(MUL_LATENCY);
   localparam logic [3:0] ITER_LAST = 4'(ITER - 1);

   logic [5:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  it_q, it_d;
   logic [31:0] s_q, s_d;
   logic [31:0] t_q, t_d;
   logic [31:0] r_q, r_d;
   logic [31:0] out_q, out_d;
   logic        out_valid_q, out_valid_d;
   logic        out_sat_q, out_sat_d;
   logic        sat_pend_q, sat_pend_d;
   logic        force_max_q, force_max_d;

   logic [31:0] mul_a, mul_b, mul_p;
   logic        mul_sat;
   logic [31:0] u;
   logic [31:0] seed;

   // Seed 3 << (30-p) puts s*r0 in [0.75,1.5) so Newton converges.
   // When the MSB is bit 31 the shift would go negative; 1 LSB keeps
   // s*r0 in [0.5,1), still inside the convergence region.
   function automatic logic [31:0] seed_recip(input logic [31:0] s);
      logic [4:0] p;
      p = 5'd0;
      for (int i = 0; i < 32; i++) begin
         if (s[i]) p = 5'(i);
      end
      if (p == 5'd31) begin
         return 32'd1;
      end
      return 32'd3 << (5'd30 - p);
   endfunction

   chol_mult_q16 #(
      .LATENCY (MUL_LATENCY)
   ) u_mult (
      .clk   (clk),
      .rst_n (rst_n),
      .ce    (clken),
      .a     (mul_a),
      .b     (mul_b),
      .p     (mul_p),
      .sat   (mul_sat)
   );

   // Sequencer: steers multiplier operands and captures products when
   // the pipe has delivered them. In S_MUL_R the extra cycle after the
   // capture is where the next s*r is issued, or the result is published.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      it_d        = it_q;
      s_d         = s_q;
      t_d         = t_q;
      r_d         = r_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      out_sat_d   = out_sat_q;
      sat_pend_d  = sat_pend_q;
      force_max_d = force_max_q;
      mul_a       = 32'd0;
      mul_b       = 32'd0;
      seed        = seed_recip(s_q);
      u           = (t_q >= Q16_TWO) ? 32'd0 : (Q16_TWO - t_q);

      if (clken) begin
         case (state_q)
            S_IDLE: begin
               mul_a = data;
               mul_b = data;
               if (data_valid) begin
                  state_d     = S_SQUARE;
                  cnt_d       = 4'd0;
                  it_d        = 4'd0;
                  out_valid_d = 1'b0;
                  out_sat_d   = 1'b0;
               end
            end
            S_SQUARE: begin
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == CNT_LAST) begin
                  s_d         = mul_p;
                  sat_pend_d  = mul_sat;
                  force_max_d = (mul_p <= 32'd1);
                  state_d     = S_SEED;
               end
            end
            S_SEED: begin
               mul_a   = s_q;
               mul_b   = seed;
               r_d     = seed;
               cnt_d   = 4'd0;
               state_d = S_MUL_T;
            end
            S_MUL_T: begin
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == CNT_LAST) begin
                  t_d     = mul_p;
                  state_d = S_SUB;
               end
            end
            S_SUB: begin
               mul_a   = r_q;
               mul_b   = u;
               cnt_d   = 4'd0;
               state_d = S_MUL_R;
            end
            S_MUL_R: begin
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == CNT_LAST) begin
                  r_d = mul_p;
               end else if (cnt_q == CNT_ISSUE) begin
                  if (it_q == ITER_LAST) begin
                     out_d       = force_max_q ? Q16_MAX : r_q;
                     out_valid_d = 1'b1;
                     out_sat_d   = sat_pend_q | force_max_q;
                     state_d     = S_IDLE;
                  end else begin
                     mul_a   = s_q;
                     mul_b   = r_q;
                     it_d    = it_q + 4'd1;
                     cnt_d   = 4'd0;
                     state_d = S_MUL_T;
                  end
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         cnt_q       <= 4'd0;
         it_q        <= 4'd0;
         s_q         <= 32'd0;
         t_q         <= 32'd0;
         r_q         <= 32'd0;
         out_q       <= 32'd0;
         out_valid_q <= 1'b0;
         out_sat_q   <= 1'b0;
         sat_pend_q  <= 1'b0;
         force_max_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         it_q        <= it_d;
         s_q         <= s_d;
         t_q         <= t_d;
         r_q         <= r_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         out_sat_q   <= out_sat_d;
         sat_pend_q  <= sat_pend_d;
         force_max_q <= force_max_d;
      end
   end

   assign ready     = (state_q == S_IDLE);
   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_chol_recip_square.sv
// ---------------------------------------------------------------------------
// tb_chol_recip_square
//   Table of directed and random y values with expected 1/y^2 results from
//   a real-arithmetic reference, plus hand-written sequences for ignored
//   mid-run requests, clock-enable freeze and mid-run reset.
// ---------------------------------------------------------------------------
module tb_chol_recip_square;

   localparam int ITER = 4;
   localparam int ML   = 3;
   localparam int LAT  = ML + 1 + ITER * (2 * ML + 2);

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clken = 1'b1;
   logic        data_valid = 1'b0;
   logic [31:0] data = 32'd0;
   logic        ready;
   logic [31:0] out;
   logic        out_valid;
   logic        out_sat;

   int n_vec  = 0;
   int n_fail = 0;

   typedef struct {
      logic [31:0] y;
      logic [31:0] exp_out;
      int unsigned tol;
      logic        exp_sat;
   } vec_t;

   vec_t vecs[$];

   chol_recip_square #(
      .ITER        (ITER),
      .MUL_LATENCY (ML)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clken      (clken),
      .data_valid (data_valid),
      .data       (data),
      .ready      (ready),
      .out        (out),
      .out_valid  (out_valid),
      .out_sat    (out_sat)
   );

   always #5 clk = ~clk;

   // Reference: square with Q16 truncation/saturation, then an exact
   // real-valued reciprocal of that square with the accuracy window.
   function automatic vec_t refModel(input logic [31:0] y);
      vec_t        v;
      logic [63:0] sq;
      logic [31:0] s;
      real         ideal;
      longint      e;
      v.y = y;
      sq  = {32'd0, y} * {32'd0, y};
      s   = sq[47:16];
      if (sq[63:48] != 16'd0) begin
         v.exp_out = 32'd1;
         v.tol     = 1;
         v.exp_sat = 1'b1;
      end else if (s <= 32'd1) begin
         v.exp_out = 32'hFFFF_FFFF;
         v.tol     = 0;
         v.exp_sat = 1'b1;
      end else begin
         ideal     = 4294967296.0 / real'(s);
         e         = longint'(ideal);
         v.exp_out = e[31:0];
         v.tol     = ((e >> 14) > 4) ? int'(e >> 14) : 4;
         v.exp_sat = 1'b0;
      end
      return v;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] got,
                              input logic [31:0] exp, input int unsigned tol);
      longint diff;
      n_vec++;
      diff = (got > exp) ? longint'({32'd0, got}) - longint'({32'd0, exp})
                         : longint'({32'd0, exp}) - longint'({32'd0, got});
      if (diff > longint'(tol)) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%08h, required 0x%08h +/- %0d", name, got, exp, tol);
      end
   endtask

   // Waits for ready, issues one request and counts edges until out_valid
   task automatic applyStimulus(input logic [31:0] y, output int cycles);
      int guard;
      guard = 0;
      while (!ready && guard < 200) begin
         @(posedge clk);
         #1;
         guard++;
      end
      data       = y;
      data_valid = 1'b1;
      @(posedge clk);
      #1;
      data_valid = 1'b0;
      cycles     = 0;
      while (!out_valid && cycles < 200) begin
         @(posedge clk);
         #1;
         cycles++;
      end
   endtask

   initial begin
      int          cyc;
      int          rises;
      logic [31:0] held;
      vec_t        v;

      // Reset state
      #12;
      checkOutput("rst_out", out, 32'd0, 0);
      checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0, 0);
      checkOutput("rst_out_sat", {31'd0, out_sat}, 32'd0, 0);
      checkOutput("rst_ready", {31'd0, ready}, 32'd1, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed table, then random vectors
      vecs.push_back('{32'h0001_0000, 32'h0001_0000, 2, 1'b0});
      vecs.push_back('{32'h0000_B505, 32'h0002_0000, 4, 1'b0});
      vecs.push_back('{32'h0004_0000, 32'h0000_1000, 2, 1'b0});
      vecs.push_back('{32'h0000_8000, 32'h0004_0000, 4, 1'b0});
      vecs.push_back('{32'h0000_0100, 32'hFFFF_FFFF, 0, 1'b1});
      vecs.push_back('{32'h0000_0000, 32'hFFFF_FFFF, 0, 1'b1});
      vecs.push_back('{32'h0100_0000, 32'h0000_0001, 1, 1'b1});
      for (int i = 0; i < 20; i++) begin
         vecs.push_back(refModel($urandom() >> $urandom_range(6, 20)));
      end

      foreach (vecs[i]) begin
         v = vecs[i];
         applyStimulus(v.y, cyc);
         checkOutput($sformatf("v%0d_y%08h_out", i, v.y), out, v.exp_out, v.tol);
         checkOutput($sformatf("v%0d_sat", i), {31'd0, out_sat}, {31'd0, v.exp_sat}, 0);
         checkOutput($sformatf("v%0d_latency", i), cyc, LAT, 0);
      end

      // Result and valid are held while idle
      held = out;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("hold_valid", {31'd0, out_valid}, 32'd1, 0);
      checkOutput("hold_out", out, held, 0);

      // data_valid pulse mid-run is ignored
      data = 32'h0001_0000;
      data_valid = 1'b1;
      @(posedge clk);
      #1;
      data_valid = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
         if (cyc == 10) data_valid = 1'b1;
         if (cyc == 10) data = 32'h0004_0000;
         if (cyc == 11) data_valid = 1'b0;
      end
      checkOutput("ignore_latency", cyc, LAT, 0);
      checkOutput("ignore_out", out, 32'h0001_0000, 2);
      held  = out;
      rises = 0;
      for (int k = 0; k < 50; k++) begin
         @(posedge clk);
         #1;
         if (!out_valid || out != held) rises++;
      end
      checkOutput("ignore_single_result", rises, 0, 0);
      checkOutput("ignore_ready", {31'd0, ready}, 32'd1, 0);

      // clken low for 10 cycles mid-run stretches latency by 10
      data = 32'h0004_0000;
      data_valid = 1'b1;
      @(posedge clk);
      #1;
      data_valid = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
         if (cyc == 5) clken = 1'b0;
         if (cyc == 15) clken = 1'b1;
      end
      clken = 1'b1;
      checkOutput("clken_latency", cyc, LAT + 10, 0);
      checkOutput("clken_out", out, 32'h0000_1000, 2);

      // Reset at cycle 20 aborts the run
      data = 32'h0001_0000;
      data_valid = 1'b1;
      @(posedge clk);
      #1;
      data_valid = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("abort_out", out, 32'd0, 0);
      checkOutput("abort_out_valid", {31'd0, out_valid}, 32'd0, 0);
      checkOutput("abort_out_sat", {31'd0, out_sat}, 32'd0, 0);
      checkOutput("abort_ready", {31'd0, ready}, 32'd1, 0);
      @(negedge clk);
      rst_n = 1'b1;
      rises = 0;
      for (int k = 0; k < 60; k++) begin
         @(posedge clk);
         #1;
         if (out_valid) rises++;
      end
      checkOutput("abort_no_late_valid", rises, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
